// File: rtl/mux_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_rr_arb
//   Multi-channel valid/ready multiplexer with a single registered output
//   stage. The arbitration mode decides which input channel is granted:
//     - mode = 0 : fixed select, only channel `sel` may be granted
//     - mode = 1 : round-robin, search starts one past the last granted
//                  channel and wraps around
//   A granted channel is readied only while the output stage can accept
//   new data, which is when it is empty or being drained this cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel used in fixed-select mode
//   in_data    NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered data of the last accepted channel
//   out_ch     registered index of the channel that sourced out_data
//   out_valid  registered output valid
//   out_ready  downstream ready
// ---------------------------------------------------------------------------
module mux_rr_arb #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Last channel granted in round-robin mode.
    logic [SELW-1:0]  ptr;

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic [WIDTH-1:0] gdata;
    logic             loadable;
    logic             xfer;
    logic             found;
    int               idx;

    assign loadable = !out_valid || out_ready;

    // Grant selection. Fixed-select compares sel against every legal index,
    // so an out-of-range sel simply matches nothing and the grant stays zero.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i])
                    grant[i] = 1'b1;
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NCH)
                    idx = idx - NCH;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // Encode the one-hot grant and pick the matching channel data.
    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gidx  = SELW'(i);
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = rst ? '0 : (grant & {NCH{loadable}});
    // A granted channel always has its valid set, so any ready bit is a transfer.
    assign xfer     = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH-1);   // first round-robin search lands on channel 0
        end else if (loadable) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_ch    <= gidx;
                if (mode)
                    ptr <= gidx;
            end else begin
                // Drained (or already empty) with nothing new: keep data, drop valid.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arb
//   Self-checking bench for mux_rr_arb (WIDTH=2, NCH=4). A behavioural model
//   tracks the output register contents and the round-robin position; every
//   cycle the DUT outputs and in_ready are compared against it. Directed
//   scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_mux_rr_arb;

    localparam int WIDTH = 2;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int m_valid, m_data, m_ch, m_ptr;

    mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected grant channel from the arbitration rules, -1 if none.
    function automatic int pick(input logic m, input int s, input logic [NCH-1:0] v, input int p);
        if (!m)
            return (s < NCH && v[s]) ? s : -1;
        for (int k = 1; k <= NCH; k++)
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        return -1;
    endfunction

    // One clock cycle: check registered outputs, apply inputs, check
    // in_ready, advance the model, then take the rising edge.
    task automatic cyc(input logic r, input logic m, input logic [SELW-1:0] s,
                       input logic [NCH*WIDTH-1:0] d, input logic [NCH-1:0] v,
                       input logic ordy);
        int g;
        logic [NCH-1:0] exp_rdy;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("out_data",  out_data,  m_data);
        chk("out_ch",    out_ch,    m_ch);
        rst = r; mode = m; sel = s; in_data = d; in_valid = v; out_ready = ordy;
        #1;
        g = pick(m, int'(s), v, m_ptr);
        exp_rdy = '0;
        if (!r && (m_valid == 0 || ordy) && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        if (r) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NCH - 1;
        end else if (m_valid == 0 || ordy) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = (d >> (g * WIDTH)) & ((1 << WIDTH) - 1);
                m_ch    = g;
                if (m) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
    endtask

    localparam logic [7:0] DFIX = {2'd2, 2'd1, 2'd0, 2'd3};

    initial begin
        int fix_exp [4];
        int seen_lo;
        fix_exp = '{3, 0, 1, 2};

        rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NCH - 1;

        // Reset state (checked at the start of the next cycle).
        cyc(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b1);

        // Fixed-select stepping.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 2'(i), DFIX, 4'b1111, 1'b1);
            #1;
            chk("fix_data", out_data, fix_exp[i]);
            chk("fix_ch",   out_ch,   i);
        end

        // Round-robin from reset: 0,1,2,3,0.
        cyc(1'b1, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);
            #1;
            chk("rr_ch",    out_ch,    i % 4);
            chk("rr_valid", out_valid, 1);
        end

        // Sparse round-robin: only 1 and 3.
        seen_lo = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1010, 1'b1);
            if (in_ready[0] || in_ready[2]) seen_lo++;
        end
        chk("sparse_lo", seen_lo, 0);

        // Backpressure: hold 3 cycles, then release.
        cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1111, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);

        // Reset mid-stream; first grant afterwards goes to channel 0.
        cyc(1'b1, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);
        #1;
        chk("rst_valid", out_valid, 0);
        cyc(1'b0, 1'b1, 2'd0, DFIX, 4'b1111, 1'b1);
        #1;
        chk("rst_first", out_ch, 0);

        // Fixed-select on an invalid channel: output drains and goes idle.
        repeat (3) cyc(1'b0, 1'b0, 2'd2, DFIX, 4'b1011, 1'b1);
        #1;
        chk("fixinv_valid", out_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom),
                8'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, 1'b1, 2'd0, '0, 4'b0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 The module SHALL have parameter WIDTH, default 2, giving the data bits per channel.
REQ-002 The module SHALL have parameter NCH, default 4, giving the channel count; legal values are 2..16.
REQ-003 The module SHALL have derived localparam SELW = clog2(NCH), giving the select and channel-index width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 The module SHALL have port mode, input, 1 bit: 0 selects fixed-select mode, 1 selects round-robin mode.
REQ-007 The module SHALL have port sel, input, SELW bits: the channel to use in fixed-select mode.
REQ-008 The module SHALL have port in_data, input, NCH*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The module SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-010 The module SHALL have port in_ready, output, NCH bits: per-channel ready, combinational.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: registered output data.
REQ-012 The module SHALL have port out_ch, output, SELW bits: registered index of the channel that sourced out_data.
REQ-013 The module SHALL have port out_valid, output, 1 bit: registered output valid.
REQ-014 The module SHALL have port out_ready, input, 1 bit: downstream ready.

Function
REQ-015 A transfer on channel i SHALL occur in any cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 The output stage SHALL be "loadable" when out_valid is 0 or out_ready is 1.
REQ-017 In fixed-select mode (mode=0), grant SHALL be one-hot on channel sel if in_valid[sel] is 1, and otherwise zero; other channels' valids SHALL be ignored.
REQ-018 In round-robin mode (mode=1), grant SHALL go to the first channel with valid set, searching from (ptr+1) mod NCH upward with wrap-around, where ptr is the last granted channel.
REQ-019 in_ready SHALL equal grant ANDed with the loadable condition; at most one bit SHALL be set per cycle.
REQ-020 in_ready SHALL NOT depend on in_valid of the non-granted channels, beyond the arbitration itself.
REQ-021 On an input transfer on channel i, the next clock SHALL set out_data to channel i's data, out_ch to i, and out_valid to 1.
REQ-022 Latency from an input transfer to out_valid SHALL be 1 cycle.
REQ-023 If the stage is loadable and no input transfer occurs, out_valid SHALL clear to 0 on the next edge; out_data and out_ch SHALL hold their values.
REQ-024 Simultaneous output transfer and input transfer in the same cycle SHALL replace the output contents with no bubble, sustaining 1 transfer per cycle.
REQ-025 When out_valid is 1 and out_ready is 0, out_data, out_ch and out_valid SHALL hold and in_ready SHALL be all zero (backpressure).
REQ-026 ptr SHALL update to the granted channel only on an input transfer in round-robin mode; fixed-select transfers SHALL leave ptr unchanged.
REQ-027 A change of mode or sel SHALL affect arbitration in the same cycle (combinational); contents already held in the output register SHALL be unaffected.
REQ-028 If sel is at or above NCH (possible only when NCH is not a power of two), grant SHALL be zero.

Reset
REQ-029 While rst is 1 at a clock edge, the module SHALL set out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so that round-robin first favours channel 0.
REQ-030 Reset SHALL override any transfer in the same cycle; held data SHALL be discarded.
REQ-031 in_ready SHALL be zero in any cycle where rst is 1.

Verification
REQ-032 Fixed-select scenario: with WIDTH=2, NCH=4, mode=0, data {d3,d2,d1,d0}={2,1,0,3}, all valids 1 and out_ready=1, stepping sel 0..3 SHALL give out_data 3,0,1,2 one cycle after each step, with out_ch equal to sel.
REQ-033 Round-robin scenario: after reset with mode=1, all valids held at 1 and out_ready=1, out_ch SHALL cycle 0,1,2,3,0 on consecutive cycles with out_valid held at 1.
REQ-034 Sparse round-robin scenario: with mode=1 and in_valid=4'b1010, grants SHALL alternate between channels 1 and 3, and channels 0 and 2 SHALL never be readied.
REQ-035 Backpressure scenario: holding out_ready=0 for 3 cycles while out_valid=1 SHALL keep out_data/out_ch stable and in_ready=0; releasing out_ready SHALL resume transfers in the next round-robin order with none lost or duplicated.
REQ-036 Reset mid-operation scenario: asserting rst for 1 cycle during streaming SHALL give out_valid=0 on the next edge, and the first grant after reset SHALL go to channel 0 in round-robin mode.
REQ-037 Fixed-select invalid scenario: with mode=0, sel=2 and in_valid[2]=0 while other valids are 1, in_ready SHALL be 0 and out_valid SHALL drop to 0 after the pending output transfers.
